// File: rtl/tile_ctrl_pkg.sv
// rtl/tile_ctrl_pkg.sv - shared types for the GEMM tile execution sequencer
package tile_ctrl_pkg;

    // Descriptor fields are held at these widths; the sequencer uses the low bits.
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DIM_W  = 16;

    typedef enum logic [1:0] {
        MODE_FW = 2'd0,
        MODE_VW = 2'd1,
        MODE_HW = 2'd2,
        MODE_IW = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH_B,
        S_STREAM_A,
        S_STORE,
        S_CHECK_NEXT
    } state_e;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] a_addr;
        logic [MAX_ADDR_W-1:0] b_addr;
        logic [MAX_ADDR_W-1:0] a_stride;
        logic [MAX_ADDR_W-1:0] b_stride;
        logic [MAX_DIM_W-1:0]  msize;
        logic [MAX_DIM_W-1:0]  ksize;
        logic [MAX_DIM_W-1:0]  nsize;
        mode_e                 mode;
        logic                  store;
    } tile_cfg_t;

    // HW and IW tiles must wait for the array before they may be chained.
    function automatic logic is_hi_mode(input mode_e m);
        return (m == MODE_HW) || (m == MODE_IW);
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - registered row address generator, reloaded once per phase
module tile_addr_gen #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              down,
    input  logic              load,
    input  logic              step,
    output logic [ADDR_W-1:0] addr
);

    // Load the phase base, then walk by one stride per accepted row (modulo 2^ADDR_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= base;
        end else if (step) begin
            addr <= down ? (addr - stride) : (addr + stride);
        end
    end

endmodule

// File: rtl/tile_exec_sequencer.sv
// rtl/tile_exec_sequencer.sv - sequences B prefetch, A stream and optional store per GEMM tile
module tile_exec_sequencer
    import tile_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_a_addr,
    input  logic [ADDR_W-1:0] cfg_b_addr,
    input  logic [ADDR_W-1:0] cfg_a_stride,
    input  logic [ADDR_W-1:0] cfg_b_stride,
    input  logic [DIM_W-1:0]  cfg_msize,
    input  logic [DIM_W-1:0]  cfg_ksize,
    input  logic [DIM_W-1:0]  cfg_nsize,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_store,
    input  logic              ready_for_hi,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DIM_W-1:0]  mem_req_len,
    input  logic              st_req_valid,
    input  logic              st_req_we,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DIM_W-1:0]  st_req_len,
    output logic              st_req_ready,
    output logic              store_start,
    input  logic              store_done,
    output logic              wfetch,
    output logic              if_en,
    output logic              prefetch_start,
    output logic              prefetch_done,
    output logic              cfg_err,
    output logic              busy,
    output logic [CNT_W-1:0]  tile_count
);

    state_e            state, state_nxt;
    tile_cfg_t         cfg_q;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  msize_q, ksize_q, nsize_q;
    logic [ADDR_W-1:0] a_addr_q, a_stride_q, b_stride_q;
    logic              accept, zero_size, last_b, last_a;
    logic              take, start;
    logic              gen_load, gen_step, gen_down;
    logic [ADDR_W-1:0] gen_base, gen_stride, gen_addr;
    logic              cfg_unused;

    assign msize_q    = cfg_q.msize[DIM_W-1:0];
    assign ksize_q    = cfg_q.ksize[DIM_W-1:0];
    assign nsize_q    = cfg_q.nsize[DIM_W-1:0];
    assign a_addr_q   = cfg_q.a_addr[ADDR_W-1:0];
    assign a_stride_q = cfg_q.a_stride[ADDR_W-1:0];
    assign b_stride_q = cfg_q.b_stride[ADDR_W-1:0];
    // Not every captured bit feeds the datapath at every parameterisation.
    assign cfg_unused = ^cfg_q;

    assign accept    = mem_req_valid && mem_req_ready;
    assign zero_size = (cfg_msize == '0) || (cfg_ksize == '0) || (cfg_nsize == '0);
    assign last_b    = (row == ksize_q - DIM_W'(1));
    assign last_a    = (row == msize_q - DIM_W'(1));
    assign busy      = (state != S_IDLE);

    tile_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .base   (gen_base),
        .stride (gen_stride),
        .down   (gen_down),
        .load   (gen_load),
        .step   (gen_step),
        .addr   (gen_addr)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state, memory-port mux, descriptor pop and address-generator control.
    always_comb begin
        state_nxt     = state;
        take          = 1'b0;
        start         = 1'b0;
        cfg_ready     = 1'b0;
        cfg_err       = 1'b0;
        store_start   = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = gen_addr;
        mem_req_len   = '0;
        st_req_ready  = 1'b0;
        gen_load      = 1'b0;
        gen_step      = 1'b0;
        gen_down      = 1'b0;
        gen_base      = cfg_b_addr;
        gen_stride    = b_stride_q;
        case (state)
            S_IDLE: begin
                take = cfg_valid;
            end
            S_PREFETCH_B: begin
                mem_req_valid = 1'b1;
                mem_req_len   = nsize_q;
                gen_down      = 1'b1;
                if (accept) begin
                    if (last_b) begin
                        gen_load  = 1'b1;
                        gen_base  = a_addr_q;
                        state_nxt = S_STREAM_A;
                    end else begin
                        gen_step = 1'b1;
                    end
                end
            end
            S_STREAM_A: begin
                mem_req_valid = 1'b1;
                mem_req_len   = ksize_q;
                gen_stride    = a_stride_q;
                if (accept) begin
                    if (last_a) begin
                        store_start = cfg_q.store;
                        state_nxt   = cfg_q.store ? S_STORE : S_CHECK_NEXT;
                    end else begin
                        gen_step = 1'b1;
                    end
                end
            end
            S_STORE: begin
                mem_req_valid = st_req_valid;
                mem_req_we    = st_req_we;
                mem_req_addr  = st_req_addr;
                mem_req_len   = st_req_len;
                st_req_ready  = mem_req_ready;
                if (store_done) state_nxt = S_CHECK_NEXT;
            end
            S_CHECK_NEXT: begin
                if (!cfg_valid) begin
                    state_nxt = S_IDLE;
                end else if (!(is_hi_mode(mode_e'(cfg_mode)) && !ready_for_hi)) begin
                    take = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // A pop either drops a zero-size head in place or launches the B prefetch.
        if (take) begin
            cfg_ready = 1'b1;
            if (zero_size) begin
                cfg_err = 1'b1;
            end else begin
                start     = 1'b1;
                gen_load  = 1'b1;
                gen_base  = cfg_b_addr;
                state_nxt = S_PREFETCH_B;
            end
        end
    end

    // Descriptor capture on pop; the FIFO head is not looked at again during the tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else if (cfg_ready) begin
            cfg_q <= '{a_addr:   MAX_ADDR_W'(cfg_a_addr),
                       b_addr:   MAX_ADDR_W'(cfg_b_addr),
                       a_stride: MAX_ADDR_W'(cfg_a_stride),
                       b_stride: MAX_ADDR_W'(cfg_b_stride),
                       msize:    MAX_DIM_W'(cfg_msize),
                       ksize:    MAX_DIM_W'(cfg_ksize),
                       nsize:    MAX_DIM_W'(cfg_nsize),
                       mode:     mode_e'(cfg_mode),
                       store:    cfg_store};
        end
    end

    // Row counter: cleared at tile start and at the B-to-A handover, advances per accepted row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (start || (state == S_PREFETCH_B && accept && last_b)) begin
            row <= '0;
        end else if (accept && (state == S_PREFETCH_B || state == S_STREAM_A)) begin
            row <= row + DIM_W'(1);
        end
    end

    // Registered pulses and data-phase qualifiers, one cycle behind their cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefetch_start <= 1'b0;
            prefetch_done  <= 1'b0;
            wfetch         <= 1'b0;
            if_en          <= 1'b0;
        end else begin
            prefetch_start <= start;
            prefetch_done  <= (state == S_PREFETCH_B) && accept && last_b;
            wfetch         <= (state == S_PREFETCH_B) && accept;
            if_en          <= (state == S_STREAM_A) && accept;
        end
    end

    // Completed-tile counter, bumped on entry to CHECK_NEXT only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_count <= '0;
        end else if (state_nxt == S_CHECK_NEXT && state != S_CHECK_NEXT) begin
            tile_count <= tile_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tile_exec_sequencer.sv
// tb/tb_tile_exec_sequencer.sv - directed self-checking bench for tile_exec_sequencer
module tb_tile_exec_sequencer;

    localparam int ADDR_W = 32;
    localparam int DIM_W  = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0, cfg_ready, cfg_store = 1'b0;
    logic [ADDR_W-1:0] cfg_a_addr = '0, cfg_b_addr = '0, cfg_a_stride = '0, cfg_b_stride = '0;
    logic [DIM_W-1:0]  cfg_msize = '0, cfg_ksize = '0, cfg_nsize = '0;
    logic [1:0]        cfg_mode = 2'd0;
    logic              ready_for_hi = 1'b0;
    logic              mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DIM_W-1:0]  mem_req_len;
    logic              st_req_valid = 1'b1, st_req_we = 1'b1, st_req_ready;
    logic [ADDR_W-1:0] st_req_addr = 32'h0000_3000;
    logic [DIM_W-1:0]  st_req_len = 5'd7;
    logic              store_start, store_done = 1'b0;
    logic              wfetch, if_en, prefetch_start, prefetch_done, cfg_err, busy;
    logic [CNT_W-1:0]  tile_count;

    always #5 clk = ~clk;

    tile_exec_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_a_addr(cfg_a_addr), .cfg_b_addr(cfg_b_addr),
        .cfg_a_stride(cfg_a_stride), .cfg_b_stride(cfg_b_stride),
        .cfg_msize(cfg_msize), .cfg_ksize(cfg_ksize), .cfg_nsize(cfg_nsize),
        .cfg_mode(cfg_mode), .cfg_store(cfg_store), .ready_for_hi(ready_for_hi),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
        .st_req_valid(st_req_valid), .st_req_we(st_req_we),
        .st_req_addr(st_req_addr), .st_req_len(st_req_len), .st_req_ready(st_req_ready),
        .store_start(store_start), .store_done(store_done),
        .wfetch(wfetch), .if_en(if_en),
        .prefetch_start(prefetch_start), .prefetch_done(prefetch_done),
        .cfg_err(cfg_err), .busy(busy), .tile_count(tile_count)
    );

    typedef struct {
        logic [31:0] a, b, a_s, b_s;
        logic [4:0]  m, k, n;
        logic [1:0]  mode;
        logic        store;
    } desc_t;

    desc_t       dq[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] rec_addr[$];
    logic [4:0]  rec_len[$];
    int          rec_cyc[$];
    int          n_wfetch, n_ifen, n_pstart, n_pdone, n_sstart, n_err, n_cfgready, n_valid;
    int          n_store_cyc, fwd_err, stab_err, n_wait, pop_cyc, pstart_cyc, pdone_cyc;
    bit          timed_out;

    function automatic desc_t mk(input logic [31:0] a, b, a_s, b_s, input logic [4:0] m, k, n,
                                 input logic [1:0] mode, input logic store);
        desc_t d;
        d.a = a; d.b = b; d.a_s = a_s; d.b_s = b_s;
        d.m = m; d.k = k; d.n = n; d.mode = mode; d.store = store;
        return d;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; mem_req_ready = 1'b0; ready_for_hi = 1'b0; store_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Plays the FIFO, memory port and store engine; records everything the DUT does.
    task automatic run_tiles(input int ready_mode, input int rfh_hold, input int stop_after);
        int          cyc = 0, sd_cnt = 0, wait_cnt = 0;
        bit          entered = 0, prev_stall = 0;
        logic [31:0] prev_addr = '0;
        logic [4:0]  prev_len = '0;
        desc_t       h;
        rec_addr.delete(); rec_len.delete(); rec_cyc.delete();
        n_wfetch = 0; n_ifen = 0; n_pstart = 0; n_pdone = 0; n_sstart = 0; n_err = 0;
        n_cfgready = 0; n_valid = 0; n_store_cyc = 0; fwd_err = 0; stab_err = 0; n_wait = 0;
        pop_cyc = -1; pstart_cyc = -1; pdone_cyc = -1; timed_out = 0;
        forever begin
            @(posedge clk); #1;
            if (!busy && dq.size() == 0) break;
            if (cyc >= 400) begin timed_out = 1; break; end
            if (!entered && tile_count != 0) entered = 1;
            if (dq.size() > 0) begin
                h = dq[0];
                cfg_valid = 1'b1; cfg_a_addr = h.a; cfg_b_addr = h.b;
                cfg_a_stride = h.a_s; cfg_b_stride = h.b_s;
                cfg_msize = h.m; cfg_ksize = h.k; cfg_nsize = h.n;
                cfg_mode = h.mode; cfg_store = h.store;
            end else begin
                cfg_valid = 1'b0;
            end
            mem_req_ready = (ready_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            ready_for_hi = (wait_cnt >= rfh_hold);
            if (entered) wait_cnt++;
            if (sd_cnt > 0) begin sd_cnt--; store_done = (sd_cnt == 0); end
            else store_done = 1'b0;
            #1;
            if (prev_stall && (!mem_req_valid || mem_req_addr !== prev_addr || mem_req_len !== prev_len))
                stab_err++;
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_addr = mem_req_addr; prev_len = mem_req_len;
            if (cfg_ready) begin n_cfgready++; pop_cyc = cyc; void'(dq.pop_front()); end
            if (cfg_err) n_err++;
            if (wfetch) n_wfetch++;
            if (if_en) n_ifen++;
            if (prefetch_start) begin n_pstart++; if (pstart_cyc < 0) pstart_cyc = cyc; end
            if (prefetch_done) begin n_pdone++; if (pdone_cyc < 0) pdone_cyc = cyc; end
            if (store_start) begin n_sstart++; sd_cnt = 5; end
            if (cfg_valid && busy && !mem_req_valid && !cfg_ready) n_wait++;
            if (mem_req_valid) n_valid++;
            if (mem_req_valid && mem_req_we) begin
                n_store_cyc++;
                if (mem_req_addr !== st_req_addr || mem_req_len !== st_req_len || st_req_ready !== mem_req_ready)
                    fwd_err++;
            end else if (st_req_ready !== 1'b0) begin
                fwd_err++;
            end
            if (mem_req_valid && mem_req_ready && !mem_req_we) begin
                rec_addr.push_back(mem_req_addr); rec_len.push_back(mem_req_len); rec_cyc.push_back(cyc);
            end
            cyc++;
            if (stop_after > 0 && rec_addr.size() == stop_after) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0;
        #3;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", mem_req_valid); end
        tests_run++; if (tile_count !== 16'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", tile_count); end
        tests_run++;
        if ({wfetch, if_en, prefetch_start, prefetch_done, cfg_ready} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_pulses: got %b want 00000", {wfetch, if_en, prefetch_start, prefetch_done, cfg_ready});
        end
        do_reset();
    endtask

    task automatic test_basic();
        logic [31:0] ea[5] = '{32'h2000, 32'h1FC0, 32'h1000, 32'h1040, 32'h1080};
        logic [4:0]  el[5] = '{5'd4, 5'd4, 5'd2, 5'd2, 5'd2};
        do_reset();
        dq.push_back(mk(32'h1000, 32'h2000, 32'h40, 32'h40, 5'd3, 5'd2, 5'd4, 2'd0, 1'b0));
        run_tiles(0, 0, 0);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL basic_timeout: got 1 want 0"); end
        tests_run++; if (rec_addr.size() != 5) begin tests_failed++; $display("FAIL basic_rows: got %0d want 5", rec_addr.size()); end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (i >= rec_addr.size() || rec_addr[i] !== ea[i] || rec_len[i] !== el[i]) begin
                tests_failed++; $display("FAIL basic_row%0d: got %h/%0d want %h/%0d", i, rec_addr[i], rec_len[i], ea[i], el[i]);
            end
        end
        tests_run++; if (rec_cyc.size() < 5 || rec_cyc[0] != pop_cyc + 1) begin tests_failed++; $display("FAIL basic_first_latency: pop %0d first %0d", pop_cyc, rec_cyc[0]); end
        tests_run++; if (rec_cyc.size() < 5 || rec_cyc[4] - rec_cyc[0] != 4) begin tests_failed++; $display("FAIL basic_bubbles: span %0d want 4", rec_cyc[4] - rec_cyc[0]); end
        tests_run++; if (tile_count !== 16'd1) begin tests_failed++; $display("FAIL basic_count: got %0d want 1", tile_count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_idle: got %b want 0", busy); end
        tests_run++; if (n_wfetch != 2 || n_ifen != 3) begin tests_failed++; $display("FAIL basic_qual: got %0d/%0d want 2/3", n_wfetch, n_ifen); end
        tests_run++; if (n_sstart != 0 || n_pstart != 1 || n_pdone != 1) begin tests_failed++; $display("FAIL basic_pulses: got %0d/%0d/%0d want 0/1/1", n_sstart, n_pstart, n_pdone); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ea[5] = '{32'h2000, 32'h1FC0, 32'h1000, 32'h1040, 32'h1080};
        logic [4:0]  el[5] = '{5'd4, 5'd4, 5'd2, 5'd2, 5'd2};
        do_reset();
        dq.push_back(mk(32'h1000, 32'h2000, 32'h40, 32'h40, 5'd3, 5'd2, 5'd4, 2'd0, 1'b0));
        run_tiles(1, 0, 0);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL bp_timeout: got 1 want 0"); end
        tests_run++; if (rec_addr.size() != 5) begin tests_failed++; $display("FAIL bp_rows: got %0d want 5", rec_addr.size()); end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (i >= rec_addr.size() || rec_addr[i] !== ea[i] || rec_len[i] !== el[i]) begin
                tests_failed++; $display("FAIL bp_row%0d: got %h/%0d want %h/%0d", i, rec_addr[i], rec_len[i], ea[i], el[i]);
            end
        end
        tests_run++; if (stab_err != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); end
        tests_run++; if (n_wfetch != 2 || n_ifen != 3) begin tests_failed++; $display("FAIL bp_qual: got %0d/%0d want 2/3", n_wfetch, n_ifen); end
        tests_run++; if (tile_count !== 16'd1) begin tests_failed++; $display("FAIL bp_count: got %0d want 1", tile_count); end
    endtask

    task automatic test_store();
        do_reset();
        dq.push_back(mk(32'h1000, 32'h2000, 32'h40, 32'h40, 5'd3, 5'd2, 5'd4, 2'd0, 1'b1));
        run_tiles(0, 0, 0);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL store_timeout: got 1 want 0"); end
        tests_run++; if (rec_addr.size() != 5) begin tests_failed++; $display("FAIL store_rows: got %0d want 5", rec_addr.size()); end
        tests_run++; if (n_sstart != 1) begin tests_failed++; $display("FAIL store_start: got %0d want 1", n_sstart); end
        tests_run++; if (n_store_cyc != 5) begin tests_failed++; $display("FAIL store_cycles: got %0d want 5", n_store_cyc); end
        tests_run++; if (fwd_err != 0) begin tests_failed++; $display("FAIL store_forward: got %0d errors want 0", fwd_err); end
        tests_run++; if (tile_count !== 16'd1 || busy !== 1'b0) begin tests_failed++; $display("FAIL store_end: got count %0d busy %b want 1/0", tile_count, busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea[6] = '{32'h200, 32'h100, 32'h110, 32'h500, 32'h4F8, 32'h400};
        logic [4:0]  el[6] = '{5'd3, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2};
        do_reset();
        dq.push_back(mk(32'h100, 32'h200, 32'h10, 32'h10, 5'd2, 5'd1, 5'd3, 2'd2, 1'b0));
        dq.push_back(mk(32'h400, 32'h500, 32'h8, 32'h8, 5'd1, 5'd2, 5'd1, 2'd2, 1'b0));
        run_tiles(0, 4, 0);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL b2b_timeout: got 1 want 0"); end
        tests_run++; if (rec_addr.size() != 6) begin tests_failed++; $display("FAIL b2b_rows: got %0d want 6", rec_addr.size()); end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (i >= rec_addr.size() || rec_addr[i] !== ea[i] || rec_len[i] !== el[i]) begin
                tests_failed++; $display("FAIL b2b_row%0d: got %h/%0d want %h/%0d", i, rec_addr[i], rec_len[i], ea[i], el[i]);
            end
        end
        tests_run++; if (n_wait != 4) begin tests_failed++; $display("FAIL b2b_wait: got %0d want 4", n_wait); end
        tests_run++; if (n_pstart != 2 || n_cfgready != 2) begin tests_failed++; $display("FAIL b2b_starts: got %0d/%0d want 2/2", n_pstart, n_cfgready); end
        tests_run++; if (pdone_cyc - pstart_cyc != 1) begin tests_failed++; $display("FAIL b2b_k1_gap: got %0d want 1", pdone_cyc - pstart_cyc); end
        tests_run++; if (tile_count !== 16'd2) begin tests_failed++; $display("FAIL b2b_count: got %0d want 2", tile_count); end
    endtask

    task automatic test_zero_size();
        do_reset();
        dq.push_back(mk(32'h1000, 32'h2000, 32'h40, 32'h40, 5'd3, 5'd0, 5'd4, 2'd0, 1'b0));
        run_tiles(0, 0, 0);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL zero_timeout: got 1 want 0"); end
        tests_run++; if (n_err != 1 || n_cfgready != 1) begin tests_failed++; $display("FAIL zero_pulses: got err %0d pop %0d want 1/1", n_err, n_cfgready); end
        tests_run++; if (n_valid != 0 || n_pstart != 0) begin tests_failed++; $display("FAIL zero_noreq: got valid %0d start %0d want 0/0", n_valid, n_pstart); end
        tests_run++; if (tile_count !== 16'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL zero_state: got count %0d busy %b want 0/0", tile_count, busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ea[3] = '{32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF8};
        logic [4:0]  el[3] = '{5'd1, 5'd1, 5'd2};
        do_reset();
        dq.push_back(mk(32'h1000, 32'h2000, 32'h40, 32'h40, 5'd3, 5'd2, 5'd4, 2'd0, 1'b0));
        run_tiles(0, 0, 0);
        tests_run++; if (tile_count !== 16'd1) begin tests_failed++; $display("FAIL mid_precount: got %0d want 1", tile_count); end
        dq.push_back(mk(32'h1000, 32'h2000, 32'h40, 32'h40, 5'd3, 5'd2, 5'd4, 2'd0, 1'b0));
        run_tiles(0, 0, 3);
        @(posedge clk); #1;
        tests_run++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1040) begin tests_failed++; $display("FAIL mid_row1: got %b/%h want 1/00001040", mem_req_valid, mem_req_addr); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (mem_req_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_abort: got valid %b busy %b want 0/0", mem_req_valid, busy); end
        tests_run++; if (tile_count !== 16'd0) begin tests_failed++; $display("FAIL mid_count: got %0d want 0", tile_count); end
        @(posedge clk); #1 rst_n = 1'b1;
        dq.push_back(mk(32'hFFFF_FFF8, 32'h0, 32'h10, 32'h10, 5'd1, 5'd2, 5'd1, 2'd1, 1'b0));
        run_tiles(0, 0, 0);
        tests_run++; if (rec_addr.size() != 3) begin tests_failed++; $display("FAIL mid_rows: got %0d want 3", rec_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i >= rec_addr.size() || rec_addr[i] !== ea[i] || rec_len[i] !== el[i]) begin
                tests_failed++; $display("FAIL mid_row%0d: got %h/%0d want %h/%0d", i, rec_addr[i], rec_len[i], ea[i], el[i]);
            end
        end
        tests_run++; if (tile_count !== 16'd1) begin tests_failed++; $display("FAIL mid_after_count: got %0d want 1", tile_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_store();
        test_back_to_back();
        test_zero_size();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
